// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw pins in, clean level and edge pulses out.
// master = debouncer side, slave = pin driver / PIO consumer side.
interface switch_debouncer_if #(
  parameter int WIDTH = 18
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

  modport slave (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch debouncer: 2-flop sync, shared tick prescaler, per-bit counter.
// Ports: clk, reset_n (async low), sw (raw in; clean/rise/fall/changed out).
module switch_debouncer #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input logic                clk,
  input logic                reset_n,
  switch_debouncer_if.master sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic [PW-1:0]            pre;
  logic                     tick;

  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_n;
  logic [WIDTH-1:0]         clean;
  logic [WIDTH-1:0]         clean_n;
  logic [WIDTH-1:0]         rise;
  logic [WIDTH-1:0]         rise_n;
  logic [WIDTH-1:0]         fall;
  logic [WIDTH-1:0]         fall_n;
  logic                     changed;

  assign tick = (pre == PRE_MAX);

  always_comb begin
    cnt_n   = cnt;
    clean_n = clean;
    rise_n  = '0;
    fall_n  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any sample agreeing with the clean level restarts the count.
      if (s2[i] == clean[i]) begin
        cnt_n[i] = '0;
      end else if (tick && cnt[i] == CNT_MAX) begin
        clean_n[i] = s2[i];
        cnt_n[i]   = '0;
        rise_n[i]  = s2[i];
        fall_n[i]  = ~s2[i];
      end else if (tick) begin
        cnt_n[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      pre     <= '0;
      cnt     <= '0;
      clean   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      s1      <= sw.sw_raw;
      s2      <= s1;
      pre     <= tick ? '0 : pre + PW'(1);
      cnt     <= cnt_n;
      clean   <= clean_n;
      rise    <= rise_n;
      fall    <= fall_n;
      changed <= |(rise_n | fall_n);
    end
  end

  assign sw.sw_clean   = clean;
  assign sw.sw_rise    = rise;
  assign sw.sw_fall    = fall;
  assign sw.sw_changed = changed;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the 18 board slide switches before they reach the switch PIO's `in_port`.
- Per-bit path: a 2-flop synchronizer, a shared sample-tick prescaler, and a per-bit stability counter.
- Outputs a clean level vector, one-cycle rise/fall pulses per bit, and an aggregate change pulse for later interrupt use.
- Sits between the top-level switch pins and the Avalon switch slave; all logic is in the system clock domain.

Parameters:
- WIDTH, 18, number of switch bits.
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range ≥1, where 1 gives a tick every cycle.
- STABLE_TICKS, 10, consecutive mismatching ticks required before a bit's clean level flips; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw asynchronous switch pins.
- sw_clean  output  WIDTH  debounced level; drives the PIO `in_port`.
- sw_rise  output  WIDTH  one-cycle pulse per bit when `sw_clean` goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when `sw_clean` goes 1→0.
- sw_changed  output  1  OR-reduction of `sw_rise | sw_fall`, registered in the same cycle as the pulses.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset is asynchronous and active-low on `reset_n`.
  - On reset, all of the following clear to 0: sync stage 1, sync stage 2, prescaler, every per-bit counter, `sw_clean`, `sw_rise`, `sw_fall`, `sw_changed`.
- Synchronizer:
  - `s1 <= sw_raw`, `s2 <= s1`.
  - Only `s2` is used downstream.
- Prescaler:
  - `pre` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is combinational, `(pre == TICK_DIV-1)`.
  - Free-running, independent of switch activity.
  - With TICK_DIV=1, `tick` is constantly 1.
- Per-bit counter `cnt[i]`, width `clog2(STABLE_TICKS+1)`, evaluated in priority order:
  1. `s2[i] == sw_clean[i]`: `cnt[i] <= 0`. This is the glitch reset and applies regardless of `tick`.
  2. Else if `tick` and `cnt[i] == STABLE_TICKS-1`: `sw_clean[i] <= s2[i]`, `cnt[i] <= 0`, and assert `sw_rise[i]` or `sw_fall[i]` according to the new value.
  3. Else if `tick`: `cnt[i] <= cnt[i] + 1`.
  4. Else: hold.
- Pulses:
  - `sw_rise`, `sw_fall` and `sw_changed` are registered and default to 0 every cycle.
  - Each is high for exactly the one cycle after the flip edge, aligned with the new `sw_clean` value.
- Latency (stable raw change to `sw_clean` update):
  - Minimum: 2 + (STABLE_TICKS-1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + STABLE_TICKS·TICK_DIV cycles.
  - The spread comes from prescaler phase.
- Bits are fully independent:
  - Simultaneous flips on several bits in one tick produce simultaneous pulses.
  - `sw_changed` is a single pulse in that case.
- Glitch shorter than STABLE_TICKS ticks: the counter is cleared, with no output change and no pulse.
- Raw toggling back exactly on the qualifying tick edge: `s2` still mismatches at that edge, so the flip occurs. A subsequent opposite debounce is then required.
- Counter never exceeds STABLE_TICKS-1, so no wrap is possible.
- Reset mid-count: asynchronous clear. After release the block restarts from `sw_clean` = 0, so switches held high debounce in again and produce `sw_rise` pulses.
- Outputs never go X after reset. No combinational path from `sw_raw` to any output.

Test Plan (TICK_DIV=4, STABLE_TICKS=3 unless stated):
- Reset release with `sw_raw`=0: all outputs 0 for ≥100 cycles; `sw_changed` never asserts.
- `sw_raw[0]` 0→1, held: `sw_clean[0]` rises 11–14 cycles later. `sw_rise[0]` and `sw_changed` are high for exactly that one cycle; `sw_fall` stays 0.
- `sw_raw[5]` high for 6 cycles, then low (fewer than 3 ticks): `sw_clean[5]` stays 0 and no pulse occurs. Repeat with a 2-cycle glitch: same result.
- `sw_raw` set to 18'h3FFFF in one cycle: all bits flip on the same cycle. `sw_rise` = 18'h3FFFF and `sw_changed` is a single 1-cycle pulse. Returning to 0 gives `sw_fall` = 18'h3FFFF.
- Assert `reset_n` low mid-count with `sw_raw[3]`=1, then release: asynchronous clear observed before the next clk edge. After release, `sw_clean[3]` rises after the full latency window with a `sw_rise[3]` pulse.
- TICK_DIV=1, STABLE_TICKS=1: each stable raw change appears on `sw_clean` exactly 3 cycles after the raw edge, with a matching pulse.
